sync_fifo_flex: RTL and testbench
=================================

// Module: sync_fifo_flex
//
// PURPOSE
// Single-clock FIFO, successor to the basic sync FIFO: any integer depth (not only 2^n),
// occupancy count, programmable almost-full/almost-empty, selectable standard or
// first-word-fall-through (FWFT) read mode, and sticky overflow/underflow error flags.
// Sits between producer/consumer blocks in one clock domain; flags drive flow control.
//
// PARAMETERS
// WIDTH      8        data word width, >=1
// DEPTH      8        entries, any integer >=2
// AFULL_TH   DEPTH-1  almost_full asserted when count >= AFULL_TH (1..DEPTH)
// AEMPTY_TH  1        almost_empty asserted when count <= AEMPTY_TH (0..DEPTH-1)
// FWFT       0        0 = standard registered read, 1 = first-word-fall-through
//
// PORTS
// clk           in   1                     clock, all logic on rising edge
// rst_n         in   1                     async active-low reset
// wr_en         in   1                     write request
// data_in       in   WIDTH                 write data
// rd_en         in   1                     read request (FWFT: pop/acknowledge head)
// data_out      out  WIDTH                 read data
// rd_valid      out  1                     data_out valid (see BEHAVIOUR)
// full          out  1                     count == DEPTH
// empty         out  1                     count == 0
// almost_full   out  1                     count >= AFULL_TH
// almost_empty  out  1                     count <= AEMPTY_TH
// count         out  $clog2(DEPTH+1)       current occupancy
// overflow      out  1                     sticky: write attempted while full
// underflow     out  1                     sticky: read attempted while empty
// err_clr       in   1                     clears overflow/underflow
//
// BEHAVIOUR
// - Reset (async assert, sync release): ptrs=0, count=0, empty=1, full=0, almost_empty=1,
//   almost_full=0, data_out=0, rd_valid=0, overflow=underflow=0. Memory not reset;
//   reset mid-operation discards all content.
// - Write accepted iff wr_en & !full; read accepted iff rd_en & !empty (registered flags).
// - Both accepted same cycle: count unchanged; full while reading -> write still rejected.
// - Pointers run 0..DEPTH-1, wrap to 0 by explicit compare (no 2^n assumption).
// - count, full, empty, almost_* all registered, computed from next count; update in the
//   cycle after the accepted operation. count never exceeds DEPTH nor goes below 0.
// - FWFT=0: on accepted read, data_out <= mem[rd_ptr] next edge, rd_valid pulses 1 cycle;
//   otherwise data_out holds, rd_valid=0. Read latency 1.
// - FWFT=1: data_out = head word, rd_valid = !empty; rd_en consumes head. Word written
//   at edge N into empty FIFO visible with rd_valid=1 after edge N (1 cycle latency).
// - overflow set on wr_en & full; underflow set on rd_en & empty; rejected ops change
//   nothing else. err_clr clears both; set wins over clear in same cycle.
// - Illegal parameters (DEPTH<2, thresholds out of range) -> elaboration-time error.
//
// STRUCTURE
// - Package sync_fifo_pkg: mode constants (FIFO_STD, FIFO_FWFT), function
//   ptr_inc(ptr, depth) for wrap, width helper cnt_w(depth) = $clog2(depth+1).
// - Sub-module sync_fifo_ram: DEPTH x WIDTH dual-port array, sync write,
//   read port comb (FWFT) or registered (STD) selected by parameter.
// - Top holds pointers, counter, flag and error logic.
//
// TESTING
// - DEPTH=6: write 6 words 0x01..0x06, no reads -> full=1 after 6th edge, count=6,
//   7th write rejected, overflow=1, count stays 6.
// - Same FIFO full, read 6 (FWFT=0) -> data_out 0x01..0x06 one cycle after each rd_en,
//   rd_valid pulses, empty=1, extra read sets underflow, data_out holds 0x06.
// - Wrap: DEPTH=6, 20 interleaved writes/reads with count in 1..5 -> output order
//   identical to input, ptrs wrap 5->0 with no loss.
// - Simultaneous wr+rd at count=3 -> count stays 3; at count=6 -> write rejected,
//   count=5, overflow=1; at count=0 (FWFT=0) -> read rejected, count=1, underflow=1.
// - FWFT=1: write 0xA5 into empty -> next cycle rd_valid=1, data_out=0xA5 with no
//   rd_en; rd_en pops -> empty=1. AFULL_TH=4, AEMPTY_TH=1 thresholds toggle at 4/1.
// - Reset asserted at count=4 with errors set -> all outputs to reset values immediately;
//   err_clr with concurrent overflow event leaves overflow=1.

Source files
------------

// File: rtl/sync_fifo_pkg.sv
// Shared constants and helpers for the flexible-depth synchronous FIFO.
// Pointer wrap is an explicit compare, so DEPTH need not be a power of two.
package sync_fifo_pkg;

  localparam int FIFO_STD  = 0;
  localparam int FIFO_FWFT = 1;

  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned depth);
    return (ptr >= depth - 1) ? 32'd0 : ptr + 32'd1;
  endfunction

endpackage

// File: rtl/sync_fifo_flex_if.sv
// Producer/consumer handshake and status bundle for sync_fifo_flex.
// The master side is the client; the slave side is the FIFO itself.
interface sync_fifo_flex_if
  import sync_fifo_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
);
  localparam int CNT_W = cnt_w(DEPTH);

  logic             wr_en;
  logic [WIDTH-1:0] data_in;
  logic             rd_en;
  logic [WIDTH-1:0] data_out;
  logic             rd_valid;
  logic             full;
  logic             empty;
  logic             almost_full;
  logic             almost_empty;
  logic [CNT_W-1:0] count;
  logic             overflow;
  logic             underflow;
  logic             err_clr;

  modport master (
    output wr_en, data_in, rd_en, err_clr,
    input  data_out, rd_valid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );

  modport slave (
    input  wr_en, data_in, rd_en, err_clr,
    output data_out, rd_valid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );

endinterface

// File: rtl/sync_fifo_ram.sv
// DEPTH x WIDTH storage: synchronous write, read port either combinational
// (fall-through) or registered with a reset-to-zero output holding register.
module sync_fifo_ram
  import sync_fifo_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 8,
  parameter int FWFT   = FIFO_STD,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Storage is intentionally not reset; occupancy alone defines valid entries.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  generate
    if (FWFT == FIFO_FWFT) begin : g_fwft
      logic unused_rd;
      assign unused_rd = re ^ rst_n;
      assign rdata     = mem[raddr];
    end else begin : g_std
      logic [WIDTH-1:0] rdata_d, rdata_q;

      always_comb begin
        rdata_d = rdata_q;
        if (re) rdata_d = mem[raddr];
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rdata_q <= '0;
        else        rdata_q <= rdata_d;
      end

      assign rdata = rdata_q;
    end
  endgenerate

endmodule

// File: rtl/sync_fifo_flex.sv
// Single-clock FIFO of arbitrary depth: pointers, occupancy counter,
// registered status flags and sticky overflow/underflow errors.
module sync_fifo_flex
  import sync_fifo_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 8,
  parameter int AFULL_TH  = DEPTH - 1,
  parameter int AEMPTY_TH = 1,
  parameter int FWFT      = FIFO_STD
) (
  input  logic            clk,
  input  logic            rst_n,
  sync_fifo_flex_if.slave bus
);

  localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W  = cnt_w(DEPTH);

  generate
    if (WIDTH < 1)                                 begin : g_bad_width  $error("sync_fifo_flex: WIDTH must be >= 1");                  end
    if (DEPTH < 2)                                 begin : g_bad_depth  $error("sync_fifo_flex: DEPTH must be >= 2");                  end
    if (AFULL_TH < 1 || AFULL_TH > DEPTH)          begin : g_bad_afull  $error("sync_fifo_flex: AFULL_TH must be in 1..DEPTH");        end
    if (AEMPTY_TH < 0 || AEMPTY_TH > DEPTH - 1)    begin : g_bad_aempty $error("sync_fifo_flex: AEMPTY_TH must be in 0..DEPTH-1");     end
    if (FWFT != FIFO_STD && FWFT != FIFO_FWFT)     begin : g_bad_mode   $error("sync_fifo_flex: FWFT must be 0 or 1");                 end
  endgenerate

  logic [ADDR_W-1:0] wr_ptr_d, wr_ptr_q, rd_ptr_d, rd_ptr_q;
  logic [CNT_W-1:0]  count_d, count_q;
  logic              full_d, full_q, empty_d, empty_q;
  logic              afull_d, afull_q, aempty_d, aempty_q;
  logic              ovf_d, ovf_q, unf_d, unf_q;
  logic              rd_valid_d, rd_valid_q;
  logic              wr_acc, rd_acc;
  logic [WIDTH-1:0]  ram_rdata;

  // Acceptance uses the registered flags, so a full FIFO rejects a write even
  // when a read frees a slot in the same cycle.
  assign wr_acc = bus.wr_en & ~full_q;
  assign rd_acc = bus.rd_en & ~empty_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_acc) wr_ptr_d = ADDR_W'(ptr_inc(32'(wr_ptr_q), DEPTH));
    if (rd_acc) rd_ptr_d = ADDR_W'(ptr_inc(32'(rd_ptr_q), DEPTH));
    unique case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Flags come from the next count so they line up with count itself.
  always_comb begin
    full_d     = (count_d == CNT_W'(DEPTH));
    empty_d    = (count_d == '0);
    afull_d    = (count_d >= CNT_W'(AFULL_TH));
    aempty_d   = (count_d <= CNT_W'(AEMPTY_TH));
    ovf_d      = (bus.wr_en & full_q)  | (ovf_q & ~bus.err_clr);
    unf_d      = (bus.rd_en & empty_q) | (unf_q & ~bus.err_clr);
    rd_valid_d = (FWFT == FIFO_STD) && rd_acc;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      afull_q    <= 1'b0;
      aempty_q   <= 1'b1;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
      rd_valid_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      afull_q    <= afull_d;
      aempty_q   <= aempty_d;
      ovf_q      <= ovf_d;
      unf_q      <= unf_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  sync_fifo_ram #(
    .WIDTH  (WIDTH),
    .DEPTH  (DEPTH),
    .FWFT   (FWFT),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (wr_acc),
    .waddr (wr_ptr_q),
    .wdata (bus.data_in),
    .re    (rd_acc),
    .raddr (rd_ptr_q),
    .rdata (ram_rdata)
  );

  // In fall-through mode the head is only meaningful while non-empty; force
  // zero otherwise so unwritten storage never leaks out.
  generate
    if (FWFT == FIFO_FWFT) begin : g_out_fwft
      assign bus.data_out = empty_q ? '0 : ram_rdata;
      assign bus.rd_valid = ~empty_q;
    end else begin : g_out_std
      assign bus.data_out = ram_rdata;
      assign bus.rd_valid = rd_valid_q;
    end
  endgenerate

  assign bus.full         = full_q;
  assign bus.empty        = empty_q;
  assign bus.almost_full  = afull_q;
  assign bus.almost_empty = aempty_q;
  assign bus.count        = count_q;
  assign bus.overflow     = ovf_q;
  assign bus.underflow    = unf_q;

endmodule

// File: tb/tb_sync_fifo_flex.sv
// Drives a standard-read and a fall-through FIFO (both DEPTH=6) with identical
// directed and random traffic and checks every output against a queue model.
module tb_sync_fifo_flex;
  import sync_fifo_pkg::*;

  localparam int W     = 8;
  localparam int D     = 6;
  localparam int S_AF  = D - 1;
  localparam int S_AE  = 1;
  localparam int F_AF  = 4;
  localparam int F_AE  = 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  sync_fifo_flex_if #(.WIDTH(W), .DEPTH(D)) bus_s ();
  sync_fifo_flex_if #(.WIDTH(W), .DEPTH(D)) bus_f ();

  sync_fifo_flex #(.WIDTH(W), .DEPTH(D), .AFULL_TH(S_AF), .AEMPTY_TH(S_AE), .FWFT(FIFO_STD))
    u_std (.clk(clk), .rst_n(rst_n), .bus(bus_s));
  sync_fifo_flex #(.WIDTH(W), .DEPTH(D), .AFULL_TH(F_AF), .AEMPTY_TH(F_AE), .FWFT(FIFO_FWFT))
    u_fw  (.clk(clk), .rst_n(rst_n), .bus(bus_f));

  int n_tests = 0;
  int n_fail  = 0;

  // reference model
  logic [W-1:0] mq[$];
  bit           m_ovf, m_unf, m_vld;
  logic [W-1:0] m_dout;

  task automatic chk(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all(input string tag);
    int n;
    n = mq.size();
    chk({tag, " s.count"}, int'(bus_s.count), n);
    chk({tag, " s.full"},  int'(bus_s.full),  int'(n == D));
    chk({tag, " s.empty"}, int'(bus_s.empty), int'(n == 0));
    chk({tag, " s.afull"}, int'(bus_s.almost_full),  int'(n >= S_AF));
    chk({tag, " s.aempty"},int'(bus_s.almost_empty), int'(n <= S_AE));
    chk({tag, " s.ovf"},   int'(bus_s.overflow),  int'(m_ovf));
    chk({tag, " s.unf"},   int'(bus_s.underflow), int'(m_unf));
    chk({tag, " s.valid"}, int'(bus_s.rd_valid),  int'(m_vld));
    chk({tag, " s.dout"},  int'(bus_s.data_out),  int'(m_dout));
    chk({tag, " f.count"}, int'(bus_f.count), n);
    chk({tag, " f.afull"}, int'(bus_f.almost_full),  int'(n >= F_AF));
    chk({tag, " f.aempty"},int'(bus_f.almost_empty), int'(n <= F_AE));
    chk({tag, " f.ovf"},   int'(bus_f.overflow),  int'(m_ovf));
    chk({tag, " f.unf"},   int'(bus_f.underflow), int'(m_unf));
    chk({tag, " f.valid"}, int'(bus_f.rd_valid),  int'(n > 0));
    chk({tag, " f.dout"},  int'(bus_f.data_out),  (n > 0) ? int'(mq[0]) : 0);
  endtask

  task automatic drive(input bit w, input logic [W-1:0] d, input bit r, input bit c);
    bus_s.wr_en = w; bus_s.data_in = d; bus_s.rd_en = r; bus_s.err_clr = c;
    bus_f.wr_en = w; bus_f.data_in = d; bus_f.rd_en = r; bus_f.err_clr = c;
  endtask

  // One clock: apply inputs, advance the model by the FIFO rules, compare.
  task automatic step(input string tag, input bit w, input logic [W-1:0] d, input bit r, input bit c);
    bit was_full, was_empty;
    drive(w, d, r, c);
    was_full  = (mq.size() == D);
    was_empty = (mq.size() == 0);
    m_ovf = (w && was_full)  || (m_ovf && !c);
    m_unf = (r && was_empty) || (m_unf && !c);
    m_vld = r && !was_empty;
    if (m_vld) m_dout = mq.pop_front();
    if (w && !was_full) mq.push_back(d);
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic do_reset(input string tag);
    drive(1'b0, '0, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    mq.delete();
    m_ovf = 0; m_unf = 0; m_vld = 0; m_dout = '0;
    check_all(tag);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    drive(1'b0, '0, 1'b0, 1'b0);
    do_reset("reset");

    // fill to full, then overflow
    for (int i = 1; i <= D; i++) step("fill", 1'b1, W'(i), 1'b0, 1'b0);
    step("wr_full", 1'b1, 8'h07, 1'b0, 1'b0);
    // clear racing a fresh overflow: set wins
    step("clr_vs_ovf", 1'b1, 8'h08, 1'b0, 1'b1);
    step("clr", 1'b0, '0, 1'b0, 1'b1);
    // wr+rd while full: write rejected
    step("wrrd_full", 1'b1, 8'h09, 1'b1, 1'b0);
    for (int i = 0; i < D - 1; i++) step("drain", 1'b0, '0, 1'b1, 1'b0);
    step("rd_empty", 1'b0, '0, 1'b1, 1'b0);
    step("idle_hold", 1'b0, '0, 1'b0, 1'b0);
    // wr+rd while empty: read rejected
    step("wrrd_empty", 1'b1, 8'h11, 1'b1, 1'b1);
    step("fill3a", 1'b1, 8'h12, 1'b0, 1'b0);
    step("fill3b", 1'b1, 8'h13, 1'b0, 1'b0);
    step("wrrd_3", 1'b1, 8'h14, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step("drain2", 1'b0, '0, 1'b1, 1'b0);
    // fall-through head appears without rd_en
    step("fw_a5", 1'b1, 8'hA5, 1'b0, 1'b0);
    step("fw_idle", 1'b0, '0, 1'b0, 1'b0);
    step("fw_pop", 1'b0, '0, 1'b1, 1'b0);

    // interleaved traffic kept within 1..5 to exercise pointer wrap
    step("wrap_pre", 1'b1, 8'h30, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      bit w, r;
      w = (mq.size() < 5) && ($urandom_range(0, 1) == 1);
      r = (mq.size() > 1) && ($urandom_range(0, 1) == 1);
      step("wrap", w, W'($urandom_range(0, 255)), r, 1'b0);
    end

    // random traffic in balanced / write-heavy / read-heavy phases
    for (int i = 0; i < 600; i++) begin
      int ph, pw, pr;
      ph = (i / 100) % 3;
      pw = (ph == 1) ? 80 : (ph == 2) ? 30 : 50;
      pr = (ph == 2) ? 80 : (ph == 1) ? 30 : 50;
      step("rand", $urandom_range(0, 99) < pw, W'($urandom_range(0, 255)),
           $urandom_range(0, 99) < pr, $urandom_range(0, 99) < 5);
    end

    // reset mid-operation with both errors set and count=4
    while (mq.size() > 0) step("pre_drain", 1'b0, '0, 1'b1, 1'b0);
    step("pre_unf", 1'b0, '0, 1'b1, 1'b0);
    for (int i = 0; i < D; i++) step("pre_fill", 1'b1, W'(8'h40 + i), 1'b0, 1'b0);
    step("pre_ovf", 1'b1, 8'h4F, 1'b0, 1'b0);
    step("pre_rd1", 1'b0, '0, 1'b1, 1'b0);
    step("pre_rd2", 1'b0, '0, 1'b1, 1'b0);
    chk("pre_rst count", int'(bus_s.count), 4);
    do_reset("mid_reset");
    step("post_rst", 1'b1, 8'h5A, 1'b0, 1'b0);
    step("post_rd", 1'b0, '0, 1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
